// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: group width and
// the helper that derives the number of lookahead groups (= pipeline depth).
package pipelined_cla_adder_pkg;

  localparam int GRP_W = 4;

  function automatic int calc_ngrp(input int width);
    return width / GRP_W;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla4_group.sv
// Combinational 4-bit carry-lookahead group with every carry expanded in full
// from the group carry-in; also exposes the carry into bit 3 for overflow.
module cla4_group (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = x & y;
  assign w_p = x | y;

  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = x ^ y ^ w_c;
  assign c3 = w_c[3];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Add/subtract pipeline: group k is resolved in stage k, and the whole pipe
// freezes when the output beat is held by the consumer (valid/ready stall).
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = calc_ngrp(WIDTH);

  // Handshake: a beat moves on a cycle where valid and ready are both 1.
  // Ready never looks at valid; it only drops while the output beat is held.
  logic w_stall;

  logic [WIDTH-1:0] w_xq  [NGRP];
  logic [WIDTH-1:0] w_yq  [NGRP];
  logic [WIDTH-1:0] w_sq  [NGRP];
  logic             w_cq  [NGRP];
  logic             w_c3q [NGRP];
  logic             w_vq  [NGRP];

  assign w_stall  = w_vq[NGRP-1] & ~out_ready;
  assign in_ready = ~w_stall | rst;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    logic [WIDTH-1:0] w_xin;
    logic [WIDTH-1:0] w_yin;
    logic [WIDTH-1:0] w_sin;
    logic [WIDTH-1:0] w_snext;
    logic             w_cin;
    logic             w_vin;
    logic [GRP_W-1:0] w_s;
    logic             w_co;
    logic             w_c3;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_c3;
    logic             r_v;

    if (k == 0) begin : g_first
      // Subtraction is x + ~y + 1, so the operand is inverted before entry.
      assign w_xin = x;
      assign w_yin = sub ? ~y : y;
      assign w_sin = '0;
      assign w_cin = sub | cin;
      assign w_vin = in_valid & in_ready;
    end else begin : g_next
      assign w_xin = w_xq[k-1];
      assign w_yin = w_yq[k-1];
      assign w_sin = w_sq[k-1];
      assign w_cin = w_cq[k-1];
      assign w_vin = w_vq[k-1];
    end

    cla4_group u_grp (
      .x  (w_xin[k*GRP_W +: GRP_W]),
      .y  (w_yin[k*GRP_W +: GRP_W]),
      .ci (w_cin),
      .s  (w_s),
      .co (w_co),
      .c3 (w_c3)
    );

    always_comb begin
      w_snext = w_sin;
      w_snext[k*GRP_W +: GRP_W] = w_s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_x  <= '0;
        r_y  <= '0;
        r_s  <= '0;
        r_c  <= 1'b0;
        r_c3 <= 1'b0;
        r_v  <= 1'b0;
      end else if (!w_stall) begin
        r_x  <= w_xin;
        r_y  <= w_yin;
        r_s  <= w_snext;
        r_c  <= w_co;
        r_c3 <= w_c3;
        r_v  <= w_vin;
      end
    end

    assign w_xq[k]  = r_x;
    assign w_yq[k]  = r_y;
    assign w_sq[k]  = r_s;
    assign w_cq[k]  = r_c;
    assign w_c3q[k] = r_c3;
    assign w_vq[k]  = r_v;
  end

  // Only the last stage's c3 is the carry into the MSB.
  assign out_valid = w_vq[NGRP-1];
  assign sum       = w_sq[NGRP-1];
  assign cout      = w_cq[NGRP-1];
  assign ovf       = w_c3q[NGRP-1] ^ w_cq[NGRP-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16): directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic [W+1:0] exp_q[$];
  int n_vec;
  int n_err;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model packed as {cout, ovf, sum}, from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    int          sa;
    int          sbv;
    int          r;
    logic [W:0]  u;
    logic [W-1:0] s;
    logic        c;
    logic        o;
    sa  = $signed(a);
    sbv = $signed(b);
    if (sb) begin
      s = a - b;
      c = (a >= b);
      r = sa - sbv;
    end else begin
      u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      s = u[W-1:0];
      c = u[W];
      r = sa + sbv + int'(ci);
    end
    o = (r > 32767) || (r < -32768);
    return {c, o, s};
  endfunction

  // driver task: one cycle, inputs at negedge, outputs sampled 1 ns later
  task automatic step(input logic vin, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb, input logic ordy, input logic rs,
                      output logic fired, output logic [W+1:0] got, output logic rdy);
    @(negedge clk);
    rst       = rs;
    in_valid  = vin;
    x         = a;
    y         = b;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    rdy   = in_ready;
    fired = out_valid & out_ready & ~rs;
    got   = {cout, ovf, sum};
    if (rs) exp_q.delete();
    else if (vin && in_ready) exp_q.push_back(model(a, b, ci, sb));
  endtask

  task automatic idle(input int n);
    logic f;
    logic [W+1:0] g;
    logic r;
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
      if (f) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_unexpected_out: got %h, required no output", g);
      end
    end
  endtask

  task automatic test_reset();
    logic f;
    logic [W+1:0] g;
    logic r;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, f, g, r);
      n_vec++;
      if (r !== 1'b1) begin
        n_err++;
        $display("FAIL reset_in_ready: got %b, required 1", r);
      end
    end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
    n_vec++;
    if (out_valid !== 1'b0 || g !== '0) begin
      n_err++;
      $display("FAIL reset_state: out_valid %b out %h, required 0 / 0", out_valid, g);
    end
    idle(6);
  endtask

  task automatic test_beat(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    logic f;
    logic [W+1:0] g;
    logic [W+1:0] e;
    logic r;
    step(1'b1, a, b, ci, sb, 1'b1, 1'b0, f, g, r);
    for (int i = 1; i <= N; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
      if (i < N) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s_latency: out_valid 1 after %0d edges, required 0", nm, i);
        end
      end else begin
        n_vec++;
        if (f !== 1'b1 || g !== {ec, eo, es}) begin
          n_err++;
          $display("FAIL %s: valid %b cout %b ovf %b sum %h, required 1 %b %b %h",
                   nm, f, g[W+1], g[W], g[W-1:0], ec, eo, es);
        end
        if (f && exp_q.size() > 0) e = exp_q.pop_front();
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic f;
    logic [W+1:0] g;
    logic [W+1:0] held;
    logic [W+1:0] e;
    logic r;
    logic [W-1:0] xa[4];
    logic [W-1:0] ya[4];
    int nfire;
    xa[0] = 16'h1111; ya[0] = 16'h2222;
    xa[1] = 16'h7FFF; ya[1] = 16'h0001;
    xa[2] = 16'hF00F; ya[2] = 16'h0FF1;
    xa[3] = 16'hABCD; ya[3] = 16'h1234;
    nfire = 0;
    held  = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 4) step(1'b1, xa[c-1], ya[c-1], 1'b0, c[0], 1'b1, 1'b0, f, g, r);
      else step(1'b0, '0, '0, 1'b0, 1'b0, !(c >= 5 && c <= 8), 1'b0, f, g, r);
      if (c >= 5 && c <= 8) begin
        n_vec++;
        if (r !== 1'b0 || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_ready: cycle %0d in_ready %b out_valid %b, required 0 1", c, r, out_valid);
        end
        if (c == 5) held = g;
        else begin
          n_vec++;
          if (g !== held) begin
            n_err++;
            $display("FAIL stall_hold: cycle %0d out %h, required %h", c, g, held);
          end
        end
      end
      if (f) begin
        nfire++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got %h, required no output", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e || c != 8 + nfire) begin
            n_err++;
            $display("FAIL b2b_order: cycle %0d got %h, required %h at cycle %0d", c, g, e, 8 + nfire);
          end
        end
      end
    end
    n_vec++;
    if (nfire != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, required 4", nfire);
    end
  endtask

  task automatic test_reset_midflight();
    logic f;
    logic [W+1:0] g;
    logic r;
    step(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
    step(1'b1, 16'h0506, 16'h0708, 1'b1, 1'b0, 1'b1, 1'b0, f, g, r);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, f, g, r);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midflight_reset: out_valid %b, required 0", out_valid);
    end
    idle(8);
  endtask

  task automatic test_random();
    logic f;
    logic [W+1:0] g;
    logic [W+1:0] e;
    logic r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] edge_v[6];
    edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h8000;
    edge_v[3] = 16'h7FFF; edge_v[4] = 16'h0001; edge_v[5] = 16'h00FF;
    for (int i = 0; i < 10000 + 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 5)] : W'($urandom);
      if (i < 10000)
        step($urandom_range(0, 3) != 0, a, b, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) != 0, 1'b0, f, g, r);
      else
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, f, g, r);
      if (f) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: got %h, required no output", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_err++;
            $display("FAIL rand_result: beat %0d got %h, required %h", i, g, e);
          end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_lost: %0d beats never emerged, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_beat("add",       16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    test_beat("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_beat("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_beat("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant: NGRP = WIDTH/4, the number of 4-bit lookahead groups and the pipeline depth.
REQ-003 Ports, clock and reset first:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = add, 1 = subtract (x - y).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Function
REQ-004 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-005 Subtract SHALL be computed as x + ~y + 1, with the internal carry-in forced to 1.
REQ-006 Each group k SHALL compute g_i = x_i&y_i and p_i = x_i|y_i, form its four carries by full lookahead (not truncated), and produce sum_i = x_i^y_i^c_i.
REQ-007 Group k SHALL be evaluated in pipeline stage k, using the group carry registered by stage k-1 (stage 0 uses the effective cin).
- Operand bits of groups above k travel with the beat in stage registers.
- Sum bits of groups already computed travel with the beat in stage registers.
REQ-008 Latency SHALL be exactly NGRP cycles: a beat accepted at edge t appears with out_valid=1 after edge t+NGRP-1, provided there is no stall.
REQ-009 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-010 Stall condition: stall = out_valid & ~out_ready. While stalled, every stage register SHALL hold its contents and in_ready SHALL be 0.
REQ-011 in_ready SHALL equal ~stall. It is a combinational function of out_ready and registered state only, and SHALL NOT depend on in_valid.
REQ-012 Each stage SHALL carry a valid bit. Bubbles (in_valid=0) SHALL propagate as invalid beats and SHALL NOT produce out_valid.
REQ-013 ovf SHALL equal (carry into bit WIDTH-1) XOR cout for the same beat.
REQ-014 sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-015 Beats SHALL emerge in acceptance order with no loss and no duplication.

Reset
REQ-016 On rst=1 at a rising edge, all stage valid bits SHALL clear to 0, and sum, cout and ovf SHALL clear to 0.
REQ-017 A reset asserted mid-operation SHALL discard every in-flight beat. out_valid SHALL be 0 in the first cycle after reset.
REQ-018 While rst=1, in_ready SHALL be 1 (no valid output exists), but no beat SHALL be captured in that cycle.

Structure
REQ-019 The shared package SHALL hold the constant GRP_W = 4 and a function computing NGRP from WIDTH.
REQ-020 One sub-module, cla4_group, SHALL implement the combinational 4-bit lookahead: inputs x[3:0], y[3:0], ci; outputs s[3:0], co, c3 (carry into bit 3).
REQ-021 The top level SHALL instantiate NGRP copies of cla4_group inside a generate loop, plus the pipeline registers and handshake logic.

Verification (WIDTH=16, NGRP=4)
REQ-022 The bench SHALL cover these directed scenarios:
- Add: x=16'h00FF, y=16'h0001, cin=0, sub=0, out_ready=1 → after 4 cycles sum=16'h0100, cout=0, ovf=0.
- Full carry chain: x=16'hFFFF, y=16'h0000, cin=1 → sum=16'h0000, cout=1, ovf=0.
- Subtract and signed overflow:
  - x=16'h8000, y=16'h0001, sub=1 → sum=16'h7FFF, cout=1, ovf=1.
  - x=16'h0003, y=16'h0005, sub=1 → sum=16'hFFFE, cout=0, ovf=0.
- Back-to-back and stall: four consecutive beats with out_ready=0 from cycle 5 to cycle 8 → in_ready=0 during the stall, the output is held, and all four results emerge in order once out_ready=1.
- Reset mid-flight: two beats in flight when rst pulses → out_valid=0 afterward, and neither discarded result ever appears.
- Random: 10,000 random x, y, cin, sub, in_valid and out_ready values, checked against a reference model for sum, cout, ovf and ordering.
